// File: rtl/pipeline_skid_buffer.sv
// pipeline_skid_buffer
// Two-entry valid/ready skid buffer. It sits between pipeline stages and
// registers both the downstream data and the upstream ready, so neither
// handshake path is combinational through this block. Items move strictly
// first-in first-out. The skid register catches the one item that can
// arrive in the same cycle that downstream stalls.
module pipeline_skid_buffer #(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              input_valid,
    output logic              input_ready,
    input  logic [WIDTH-1:0]  input_data,
    output logic              output_valid,
    input  logic              output_ready,
    output logic [WIDTH-1:0]  output_data
);

    // Occupancy of the buffer: EMPTY = nothing held,
    // BUSY = one item (output register), FULL = two items (output + skid).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   data_r;
    logic [WIDTH-1:0]   data_next_s;
    logic [WIDTH-1:0]   skid_r;
    logic [WIDTH-1:0]   skid_next_s;
    logic               input_ready_r;
    logic               output_valid_r;
    logic               load_s;
    logic               unload_s;

    // Handshake events, qualified by the registered flags the partners actually see.
    always_comb begin
        load_s   = input_valid & input_ready_r;
        unload_s = output_valid_r & output_ready;
    end

    // Next-state and data-path selection. Every path holds by default.
    always_comb begin
        state_next_s = state_r;
        data_next_s  = data_r;
        skid_next_s  = skid_r;
        case (state_r)
            ST_EMPTY: begin
                if (load_s) begin
                    state_next_s = ST_BUSY;
                    data_next_s  = input_data;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (load_s && !unload_s) begin
                    // Downstream stalled while a new item arrived: park it in the skid.
                    state_next_s = ST_FULL;
                    skid_next_s  = input_data;
                end else if (load_s && unload_s) begin
                    // Flow-through: the new item replaces the one just consumed.
                    state_next_s = ST_BUSY;
                    data_next_s  = input_data;
                end else if (unload_s) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_FULL: begin
                // No load is possible here because input_ready is low.
                if (unload_s) begin
                    state_next_s = ST_BUSY;
                    data_next_s  = skid_r;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: begin
                // An unreachable encoding recovers to a clean empty buffer.
                state_next_s = ST_EMPTY;
                data_next_s  = RESET_VALUE;
                skid_next_s  = RESET_VALUE;
            end
        endcase
    end

    // State, data and handshake flag registers. Reset and flush are identical, so any same-cycle transfer is void.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_r        <= ST_EMPTY;
            data_r         <= RESET_VALUE;
            skid_r         <= RESET_VALUE;
            input_ready_r  <= 1'b1;
            output_valid_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            data_r         <= data_next_s;
            skid_r         <= skid_next_s;
            input_ready_r  <= (state_next_s != ST_FULL);
            output_valid_r <= (state_next_s != ST_EMPTY);
        end
    end

    assign input_ready  = input_ready_r;
    assign output_valid = output_valid_r;
    assign output_data  = data_r;

endmodule

// File: tb/tb_pipeline_skid_buffer.sv
// Self-checking bench for pipeline_skid_buffer. It uses WIDTH=8 and RESET_VALUE=8'hA5.
// A directed vector table covers reset, skid fill/drain, backpressure and
// flush. Hand-written sequences cover streaming and a random-stall run.
// The random-stall run is checked against a queue model.
module tb_pipeline_skid_buffer;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic         clk;
    logic         rst;
    logic         clear;
    logic         input_valid;
    logic         input_ready;
    logic [W-1:0] input_data;
    logic         output_valid;
    logic         output_ready;
    logic [W-1:0] output_data;

    int n_vec;
    int n_fail;

    pipeline_skid_buffer #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       clr;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
    } vec_t;

    vec_t vecs [0:20];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic iv, input logic [7:0] d, input logic o);
        rst          = r;
        clear        = c;
        input_valid  = iv;
        input_data   = d;
        output_ready = o;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sb_q [$];
    logic [7:0] next_val;
    logic       ld;
    logic       ul;
    logic       iv_r;
    logic       or_r;

    initial begin
        n_vec  = 0;
        n_fail = 0;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        //            rst   clr   iv    d      ordy  e_ir  e_ov  e_od
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'hA5}; // reset with offered data
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'hA5};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 8'hA5}; // idle, 11 never captured
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01}; // EMPTY -> BUSY
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01}; // BUSY -> FULL
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h01}; // backpressure
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h01};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h01};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h02}; // 01 out, skid 02 moves up
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33}; // flow-through, 33 loaded
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h33}; // drain to EMPTY
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h44};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h44}; // FULL
        vecs[13] = '{1'b0, 1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 8'hA5}; // clear in FULL
        vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5}; // nothing re-emitted
        vecs[15] = '{1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 8'h77};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 8'h77}; // FULL
        vecs[17] = '{1'b1, 1'b0, 1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 8'hA5}; // rst in FULL
        vecs[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 8'hA5}; // clear voids a load
        vecs[20] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5};

        for (int i = 0; i <= 20; i++) begin
            drive(vecs[i].rst, vecs[i].clr, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            step();
            n_vec++;
            chk($sformatf("vec%0d input_ready", i),  {7'd0, input_ready},  {7'd0, vecs[i].e_ir});
            chk($sformatf("vec%0d output_valid", i), {7'd0, output_valid}, {7'd0, vecs[i].e_ov});
            chk($sformatf("vec%0d output_data", i),  output_data,          vecs[i].e_od);
        end

        // Streaming: 00..0F back-to-back with downstream always ready.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
            step();
            n_vec++;
            chk($sformatf("stream%0d input_ready", i),  {7'd0, input_ready},  8'h01);
            chk($sformatf("stream%0d output_valid", i), {7'd0, output_valid}, 8'h01);
            chk($sformatf("stream%0d output_data", i),  output_data,          8'(i));
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step();
        n_vec++;
        chk("stream_end output_valid", {7'd0, output_valid}, 8'h00);
        chk("stream_end output_data",  output_data,          8'h0F);

        // Random stall against a queue model; data is a running count, so a drop or duplicate shows.
        next_val = 8'h00;
        sb_q.delete();
        for (int c = 0; c < 1000; c++) begin
            iv_r = ($urandom_range(0, 99) < 60);
            or_r = ($urandom_range(0, 99) < 55);
            drive(1'b0, 1'b0, iv_r, next_val, or_r);
            ld = iv_r & input_ready;
            ul = output_valid & or_r;
            step();
            n_vec++;
            if (ul) begin
                if (sb_q.size() > 0) begin
                    void'(sb_q.pop_front());
                end else begin
                    n_fail++;
                    $display("FAIL rand%0d unload from empty model", c);
                end
            end
            if (ld) begin
                sb_q.push_back(next_val);
                next_val = next_val + 8'd1;
            end
            chk($sformatf("rand%0d output_valid", c), {7'd0, output_valid}, {7'd0, (sb_q.size() > 0)});
            chk($sformatf("rand%0d input_ready", c),  {7'd0, input_ready},  {7'd0, (sb_q.size() < 2)});
            if (sb_q.size() > 0) begin
                chk($sformatf("rand%0d output_data", c), output_data, sb_q[0]);
            end
        end

        // Drain whatever is left and confirm it arrives in order.
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            ul = output_valid;
            step();
            n_vec++;
            if (ul && sb_q.size() > 0) begin
                void'(sb_q.pop_front());
            end
            chk($sformatf("drain%0d output_valid", c), {7'd0, output_valid}, {7'd0, (sb_q.size() > 0)});
            if (sb_q.size() > 0) begin
                chk($sformatf("drain%0d output_data", c), output_data, sb_q[0]);
            end
        end
        chk("drain model empty", 8'(sb_q.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
